// File: rtl/snp_bus_pkg.sv
// Shared types and helpers for the snoop-bus controller: bus ops, snoop responses,
// controller states and the round-robin pointer step.
package snp_bus_pkg;

    typedef enum logic [2:0] {
        OP_NONE     = 3'b000,
        OP_BUS_RD   = 3'b001,
        OP_BUS_RDX  = 3'b010,
        OP_BUS_UPGR = 3'b011,
        OP_BUS_WB   = 3'b100
    } snp_op_e;

    typedef enum logic [1:0] {
        RSP_NO_RSP = 2'b00,
        RSP_FOUND  = 2'b01,
        RSP_FETCH  = 2'b10,
        RSP_DONE   = 2'b11
    } snp_rsp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BCAST,
        ST_MEM,
        ST_RESP
    } bus_state_e;

    // Encodings 101..111 are not bus ops and never request the bus.
    function automatic logic op_is_active(input logic [2:0] op);
        return (op >= OP_BUS_RD) && (op <= OP_BUS_WB);
    endfunction

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping; one-hot and index forms.
module rr_arbiter
    import snp_bus_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = ptr;
        for (int unsigned k = 0; k < N; k++) begin
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
            cand = IW'(rr_next(32'(cand), N));
        end
    end

endmodule

// File: rtl/snp_bus_arbiter.sv
// Shared snoop-bus controller: round-robin grant, peer snoop broadcast, memory fallback
// and a single response pulse back to the requesting cache.
module snp_bus_arbiter
    import snp_bus_pkg::*;
#(
    parameter int NUM_CACHE   = 4,
    parameter int SADDR_WIDTH = 58,
    parameter int BLK_WIDTH   = 512
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_CACHE-1:0][2:0]              rx_req_op,
    input  logic [NUM_CACHE-1:0][SADDR_WIDTH-1:0]  rx_req_addr,
    input  logic [NUM_CACHE-1:0][BLK_WIDTH-1:0]    rx_req_data,
    output logic [NUM_CACHE-1:0][2:0]              tx_snp_op,
    output logic [SADDR_WIDTH-1:0]                 tx_snp_addr,
    input  logic [NUM_CACHE-1:0][1:0]              rx_snp_rsp,
    input  logic [NUM_CACHE-1:0][BLK_WIDTH-1:0]    rx_snp_data,
    output logic [NUM_CACHE-1:0][1:0]              tx_req_rsp,
    output logic [BLK_WIDTH-1:0]                   tx_req_data,
    output logic                                   mem_req,
    output logic                                   mem_we,
    output logic [SADDR_WIDTH-1:0]                 mem_addr,
    output logic [BLK_WIDTH-1:0]                   mem_wdata,
    input  logic [BLK_WIDTH-1:0]                   mem_rdata,
    input  logic                                   mem_ack
);

    localparam int unsigned NC = NUM_CACHE;
    localparam int unsigned IW = $clog2(NUM_CACHE);

    bus_state_e             state, state_n;
    logic [IW-1:0]          rr_ptr, gnt_idx;
    logic [2:0]             op_q;
    logic [SADDR_WIDTH-1:0] addr_q;
    logic [BLK_WIDTH-1:0]   data_q;
    snp_rsp_e               rsp_q;
    logic                   we_q;

    logic [NC-1:0]          req_vec, arb_grant;
    logic [IW-1:0]          arb_idx;
    logic                   arb_valid;
    logic [2:0]             sel_op;
    logic [SADDR_WIDTH-1:0] sel_addr;
    logic [BLK_WIDTH-1:0]   sel_data;
    logic                   peer_hit;
    logic [BLK_WIDTH-1:0]   peer_data;

    always_comb begin
        for (int unsigned i = 0; i < NC; i++) req_vec[i] = op_is_active(rx_req_op[i]);
    end

    rr_arbiter #(.N(NC), .IW(IW)) u_rr (
        .req   (req_vec),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        sel_op   = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (arb_grant[i]) begin
                sel_op   = sel_op   | rx_req_op[i];
                sel_addr = sel_addr | rx_req_addr[i];
                sel_data = sel_data | rx_req_data[i];
            end
        end
    end

    // Lowest-index peer wins; the requester's own snoop port is never considered.
    always_comb begin
        peer_hit  = 1'b0;
        peer_data = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (!peer_hit && IW'(i) != gnt_idx && rx_snp_rsp[i] == RSP_FOUND) begin
                peer_hit  = 1'b1;
                peer_data = rx_snp_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n     = state;
        tx_snp_op   = '0;
        tx_snp_addr = '0;
        tx_req_rsp  = '0;
        tx_req_data = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (state == ST_BCAST && IW'(i) != gnt_idx) tx_snp_op[i] = op_q;
        end
        unique case (state)
            ST_IDLE: begin
                if (arb_valid) state_n = (sel_op == OP_BUS_WB) ? ST_MEM : ST_BCAST;
            end
            ST_BCAST: begin
                tx_snp_addr = addr_q;
                if (op_q == OP_BUS_UPGR || peer_hit) state_n = ST_RESP;
                else                                 state_n = ST_MEM;
            end
            ST_MEM: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                if (we_q) mem_wdata = data_q;
                if (mem_ack) state_n = ST_RESP;
            end
            ST_RESP: begin
                tx_req_rsp[gnt_idx] = rsp_q;
                tx_req_data         = data_q;
                state_n             = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // data_q carries writeback data into MEM, then the response block out of RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            gnt_idx <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rsp_q   <= RSP_NO_RSP;
            we_q    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        gnt_idx <= arb_idx;
                        op_q    <= sel_op;
                        addr_q  <= sel_addr;
                        data_q  <= sel_data;
                        we_q    <= (sel_op == OP_BUS_WB);
                    end
                end
                ST_BCAST: begin
                    if (op_q == OP_BUS_UPGR) begin
                        rsp_q  <= RSP_DONE;
                        data_q <= '0;
                    end else if (peer_hit) begin
                        rsp_q  <= RSP_FOUND;
                        data_q <= peer_data;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        rsp_q  <= we_q ? RSP_DONE : RSP_FETCH;
                        data_q <= we_q ? '0 : mem_rdata;
                    end
                end
                ST_RESP: rr_ptr <= IW'(rr_next(32'(gnt_idx), NC));
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snp_bus_arbiter.sv
// Bench for snp_bus_arbiter: transaction-level bus model checked every cycle, directed
// scenarios with literal expectations, then randomized cache/memory traffic with resets.
`timescale 1ns/1ps
module tb_snp_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 58;
    localparam int BW = 512;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0][2:0]    rx_req_op;
    logic [N-1:0][AW-1:0] rx_req_addr;
    logic [N-1:0][BW-1:0] rx_req_data;
    logic [N-1:0][2:0]    tx_snp_op;
    logic [AW-1:0]        tx_snp_addr;
    logic [N-1:0][1:0]    rx_snp_rsp;
    logic [N-1:0][BW-1:0] rx_snp_data;
    logic [N-1:0][1:0]    tx_req_rsp;
    logic [BW-1:0]        tx_req_data;
    logic                 mem_req, mem_we, mem_ack;
    logic [AW-1:0]        mem_addr;
    logic [BW-1:0]        mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    snp_bus_arbiter #(.NUM_CACHE(N), .SADDR_WIDTH(AW), .BLK_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_req_op(rx_req_op), .rx_req_addr(rx_req_addr), .rx_req_data(rx_req_data),
        .tx_snp_op(tx_snp_op), .tx_snp_addr(tx_snp_addr),
        .rx_snp_rsp(rx_snp_rsp), .rx_snp_data(rx_snp_data),
        .tx_req_rsp(tx_req_rsp), .tx_req_data(tx_req_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] v;
        for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [BW-1:0] fill8(input logic [7:0] b);
        return {(BW/8){b}};
    endfunction

    // Reference model: who owns the bus and which phase of its transaction is visible.
    int            m_owner, m_ptr, mh, mc;
    bit            m_snoop, m_mem, m_reply, m_wr;
    logic [2:0]    m_op;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_wdata, m_data;
    logic [1:0]    m_rsp;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner = -1; m_ptr = 0; m_snoop = 0; m_mem = 0; m_reply = 0; m_wr = 0;
        end else if (m_reply) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_reply = 0;
        end else if (m_snoop) begin
            mh = -1;
            for (int j = N - 1; j >= 0; j--)
                if (j != m_owner && rx_snp_rsp[j] == 2'b01) mh = j;
            m_snoop = 0;
            if (m_op == 3'd3) begin
                m_reply = 1; m_rsp = 2'b11;
            end else if (mh >= 0) begin
                m_reply = 1; m_rsp = 2'b01; m_data = rx_snp_data[mh];
            end else begin
                m_mem = 1; m_wr = 0;
            end
        end else if (m_mem) begin
            if (mem_ack) begin
                m_mem = 0; m_reply = 1;
                m_rsp  = m_wr ? 2'b11 : 2'b10;
                m_data = mem_rdata;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                mc = (m_ptr + k) % N;
                if (m_owner < 0 && rx_req_op[mc] >= 3'd1 && rx_req_op[mc] <= 3'd4) begin
                    m_owner = mc; m_op = rx_req_op[mc];
                    m_addr = rx_req_addr[mc]; m_wdata = rx_req_data[mc];
                    if (m_op == 3'd4) begin m_mem = 1; m_wr = 1; end
                    else m_snoop = 1;
                end
            end
        end
    end

    logic [N-1:0][2:0] e_snp;
    logic [N-1:0][1:0] e_rsp;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) e_snp[i] = (m_snoop && i != m_owner) ? m_op : 3'd0;
            e_rsp = '0;
            if (m_reply) e_rsp[m_owner] = m_rsp;
            chk("tx_snp_op", BW'(tx_snp_op), BW'(e_snp));
            chk("tx_req_rsp", BW'(tx_req_rsp), BW'(e_rsp));
            chk("mem_req", BW'(mem_req), BW'(m_mem));
            chk("mem_we", BW'(mem_we), BW'(m_mem && m_wr));
            if (m_snoop) chk("tx_snp_addr", BW'(tx_snp_addr), BW'(m_addr));
            if (m_mem) chk("mem_addr", BW'(mem_addr), BW'(m_addr));
            if (m_mem && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
            if (m_reply && m_rsp != 2'b11) chk("tx_req_data", tx_req_data, m_data);
        end
    end

    // Memory agent: ack after a programmable (or random) number of cycles; optional stray acks.
    int            mem_lat_knob = 0;
    bit            mem_data_fixed = 0, spur_en = 0, mcounting = 0;
    logic [BW-1:0] mem_data_val;
    int            mcnt;

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req === 1'b1) begin
            if (!mcounting) begin
                mcounting = 1;
                mcnt = (mem_lat_knob >= 0) ? mem_lat_knob : int'($urandom_range(0, 4));
            end
            if (mcnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_data_fixed ? mem_data_val : rand_blk();
                mcounting = 0;
            end else mcnt--;
        end else begin
            mcounting = 0;
            if (spur_en && $urandom_range(0, 5) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = rand_blk();
            end
        end
    end

    bit                saw_snp, saw_mem, saw_we;
    logic [BW-1:0]     saw_wdata;
    logic [N-1:0][2:0] snp_at1;
    int                ord[8];
    int                ord_n;

    task automatic wait_rsp(input int c, input int budget, output logic [1:0] r,
                            output logic [BW-1:0] d, output int cyc);
        r = 2'b00; d = '0; cyc = 0;
        saw_snp = 0; saw_mem = 0; saw_we = 0; saw_wdata = '0; snp_at1 = '0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) snp_at1 = tx_snp_op;
            if (tx_snp_op != '0) saw_snp = 1;
            if (mem_req) begin saw_mem = 1; saw_we = mem_we; saw_wdata = mem_wdata; end
            if (tx_req_rsp[c] != 2'b00) begin r = tx_req_rsp[c]; d = tx_req_data; break; end
        end
        if (r == 2'b00) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout cache%0d: got no response, expected one within %0d cycles", c, budget);
        end
    endtask

    task automatic txn(input int c, input logic [2:0] op, input logic [AW-1:0] a,
                       input logic [BW-1:0] wd, output logic [1:0] r,
                       output logic [BW-1:0] d, output int cyc);
        @(negedge clk);
        rx_req_op[c] = op; rx_req_addr[c] = a; rx_req_data[c] = wd;
        wait_rsp(c, 40, r, d, cyc);
        rx_req_op[c] = 3'b000;
    endtask

    // Hold RD on every cache in mask and log which cache answers, until count responses.
    task automatic collect(input logic [N-1:0] mask, input int count);
        int budget;
        @(negedge clk);
        ord_n = 0; budget = 0;
        for (int c = 0; c < N; c++)
            if (mask[c]) begin
                rx_req_op[c] = 3'b001; rx_req_addr[c] = AW'(64'h100 + c); rx_req_data[c] = '0;
            end
        while (ord_n < count && budget < 100) begin
            @(negedge clk);
            budget++;
            for (int c = 0; c < N; c++)
                if (tx_req_rsp[c] != 2'b00 && ord_n < 8) begin ord[ord_n] = c; ord_n++; end
        end
        for (int c = 0; c < N; c++) if (mask[c]) rx_req_op[c] = 3'b000;
        if (ord_n < count) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout collect: got %0d responses expected %0d", ord_n, count);
        end
    endtask

    logic [1:0]    r;
    logic [BW-1:0] d;
    int            cyc;
    int            exp_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        rx_req_op = '0; rx_req_addr = '0; rx_req_data = '0;
        rx_snp_rsp = '0; rx_snp_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        mem_data_val = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset tx_snp_op", BW'(tx_snp_op), '0);
        chk("reset tx_req_rsp", BW'(tx_req_rsp), '0);
        chk("reset mem_req", BW'(mem_req), '0);
        chk("reset tx_req_data", tx_req_data, '0);
        chk("reset mem_addr", BW'(mem_addr), '0);
        chk_en = 1;
        rst_n = 1'b1;

        // Simultaneous requests rotate 0,1,2,3 and come back to 0.
        for (int c = 0; c < N; c++) begin
            rx_snp_rsp[c] = 2'b01; rx_snp_data[c] = fill8(8'h10 + 8'(c));
        end
        collect(4'b1111, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("rr order %0d", i), BW'(ord[i]), BW'(exp_ord[i]));

        // Peer hit: cache2 supplies the block to cache1.
        rx_snp_rsp = '0; rx_snp_rsp[2] = 2'b01; rx_snp_data[2] = fill8(8'hAA);
        txn(1, 3'b001, AW'(64'h40), '0, r, d, cyc);
        chk("hit snoop ops", BW'(snp_at1), BW'(12'b001_001_000_001));
        chk("hit rsp", BW'(r), BW'(2'b01));
        chk("hit data", d, fill8(8'hAA));
        chk("hit latency", BW'(cyc), BW'(2));

        // Miss: RDX goes to memory, ack three cycles after the request.
        rx_snp_rsp = '0;
        mem_lat_knob = 3; mem_data_fixed = 1; mem_data_val = fill8(8'h55);
        txn(0, 3'b010, AW'(64'h80), '0, r, d, cyc);
        chk("miss rsp", BW'(r), BW'(2'b10));
        chk("miss data", d, fill8(8'h55));
        chk("miss mem_we", BW'(saw_we), BW'(0));
        chk("miss latency", BW'(cyc), BW'(6));

        // Writeback: straight to memory, no broadcast.
        mem_lat_knob = 1;
        txn(3, 3'b100, AW'(64'h10), fill8(8'h77), r, d, cyc);
        chk("wb rsp", BW'(r), BW'(2'b11));
        chk("wb no snoop", BW'(saw_snp), BW'(0));
        chk("wb mem_we", BW'(saw_we), BW'(1));
        chk("wb wdata", saw_wdata, fill8(8'h77));
        chk("wb latency", BW'(cyc), BW'(3));

        // Upgrade with two sharers, then the same peers answering a read.
        rx_snp_rsp = '0; rx_snp_rsp[0] = 2'b01; rx_snp_rsp[1] = 2'b01;
        rx_snp_data[0] = fill8(8'hC0); rx_snp_data[1] = fill8(8'hC1);
        txn(2, 3'b011, AW'(64'h200), '0, r, d, cyc);
        chk("upgr rsp", BW'(r), BW'(2'b11));
        chk("upgr latency", BW'(cyc), BW'(2));
        chk("upgr no mem", BW'(saw_mem), BW'(0));
        txn(2, 3'b001, AW'(64'h200), '0, r, d, cyc);
        chk("rd lowest peer rsp", BW'(r), BW'(2'b01));
        chk("rd lowest peer data", d, fill8(8'hC0));

        // Reset while waiting on memory; pointer must also return to 0.
        rx_snp_rsp = '0; mem_lat_knob = 20;
        @(negedge clk);
        rx_req_op[1] = 3'b001; rx_req_addr[1] = AW'(64'h300);
        cyc = 0;
        while (!mem_req && cyc < 10) begin @(negedge clk); cyc++; end
        chk("reset-mid reached mem", BW'(mem_req), BW'(1));
        rst_n = 1'b0; rx_req_op[1] = 3'b000;
        @(negedge clk);
        chk("reset-mid mem_req", BW'(mem_req), '0);
        chk("reset-mid mem_addr", BW'(mem_addr), '0);
        chk("reset-mid tx_snp_op", BW'(tx_snp_op), '0);
        rst_n = 1'b1;
        rx_snp_rsp = '0; rx_snp_rsp[1] = 2'b01; rx_snp_data[1] = fill8(8'hD1);
        collect(4'b1001, 2);
        chk("ptr after reset first", BW'(ord[0]), BW'(0));
        chk("ptr after reset second", BW'(ord[1]), BW'(3));

        // Random traffic with stray acks and occasional resets.
        mem_lat_knob = -1; mem_data_fixed = 0; spur_en = 1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                if (rx_req_op[c] >= 3'd1 && rx_req_op[c] <= 3'd4) begin
                    if (tx_req_rsp[c] != 2'b00) rx_req_op[c] = 3'b000;
                end else if ($urandom_range(0, 3) == 0) begin
                    rx_req_op[c] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                               : 3'($urandom_range(1, 4));
                    rx_req_addr[c] = AW'({$urandom, $urandom});
                    rx_req_data[c] = rand_blk();
                end else rx_req_op[c] = 3'b000;
                rx_snp_rsp[c]  = 2'($urandom_range(0, 3));
                rx_snp_data[c] = rand_blk();
            end
            rst_n = ($urandom_range(0, 299) != 0);
        end
        rx_req_op = '0; rst_n = 1'b1; spur_en = 0;
        repeat (40) @(negedge clk);
        chk("drain idle rsp", BW'(tx_req_rsp), '0);
        chk("drain idle mem", BW'(mem_req), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
